// File: rtl/add_sub_arbiter_pkg.sv
// Shared definitions for the two-requester add/sub arbiter: defaults,
// operation selects and FSM state encodings.
package add_sub_arbiter_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int SEL_W_DEF = 3;

   localparam logic [2:0] SEL_ADD = 3'b000;
   localparam logic [2:0] SEL_SUB = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Round-robin pick: lone requester wins, ties go to the priority holder.
   function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic prio);
      logic [1:0] g;
      g = 2'b00;
      case (valid)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = prio ? 2'b10 : 2'b01;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/add_sub_arbiter_add_sub.sv
// Shared combinational adder/subtractor. Carry is bit WIDTH of the
// zero-extended sum or difference; reserved selects produce zero.
module add_sub_arbiter_add_sub
   import add_sub_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic [SEL_W-1:0] sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH:0] ext;

   always_comb begin
      ext = '0;
      if (sel == SEL_W'(SEL_ADD))
         ext = {1'b0, a} + {1'b0, b};
      else if (sel == SEL_W'(SEL_SUB))
         ext = {1'b0, a} - {1'b0, b};
   end

   assign out   = ext[WIDTH-1:0];
   assign carry = ext[WIDTH];
   assign zero  = (ext[WIDTH-1:0] == '0);

endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin front end sharing one add_sub between two requesters, one
// operation in flight, with registered operands and a held response.
module add_sub_arbiter
   import add_sub_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [SEL_W-1:0] req_sel0,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [SEL_W-1:0] req_sel1,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             busy
);

   state_t           state;
   logic             prio;
   logic             gnt_id;
   logic [SEL_W-1:0] op_sel;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   logic             grant_id;
   logic [SEL_W-1:0] in_sel;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] as_out;
   logic             as_carry;
   logic             as_zero;

   // Ready is only offered in IDLE and is held off while reset is asserted.
   always_comb begin
      req_ready = 2'b00;
      if (rst_n && state == ST_IDLE)
         req_ready = rr_pick(req_valid, prio);
   end

   assign grant_id = req_ready[1];
   assign in_sel   = grant_id ? req_sel1 : req_sel0;
   assign in_a     = grant_id ? req_a1   : req_a0;
   assign in_b     = grant_id ? req_b1   : req_b0;
   assign busy     = (state != ST_IDLE);

   add_sub_arbiter_add_sub #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_add_sub (
      .sel   (op_sel),
      .a     (op_a),
      .b     (op_b),
      .out   (as_out),
      .carry (as_carry),
      .zero  (as_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         prio      <= 1'b0;
         gnt_id    <= 1'b0;
         op_sel    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_out   <= '0;
         rsp_carry <= 1'b0;
         rsp_zero  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|(req_valid & req_ready)) begin
                  op_sel <= in_sel;
                  op_a   <= in_a;
                  op_b   <= in_b;
                  gnt_id <= grant_id;
                  prio   <= ~grant_id;
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_out   <= as_out;
               rsp_carry <= as_carry;
               rsp_zero  <= as_zero;
               rsp_id    <= gnt_id;
               rsp_valid <= 1'b1;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Directed bench for add_sub_arbiter: stimulus pushes expected responses into
// a scoreboard, a negedge monitor pops and compares each response transfer.
module tb_add_sub_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [2:0]  req_sel0, req_sel1;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_out;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        id;
      logic [31:0] out;
      logic        carry;
      logic        zero;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   add_sub_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sel0  (req_sel0),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_sel1  (req_sel1),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_out   (rsp_out),
      .rsp_carry (rsp_carry),
      .rsp_zero  (rsp_zero),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every response transfer must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected got out=%0h want no response", rsp_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_id",    64'(rsp_id),    64'(e.id));
            chk("rsp_out",   64'(rsp_out),   64'(e.out));
            chk("rsp_carry", 64'(rsp_carry), 64'(e.carry));
            chk("rsp_zero",  64'(rsp_zero),  64'(e.zero));
         end
      end
   end

   task automatic drive(input int id, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
      if (id == 0) begin
         req_sel0 = sel; req_a0 = a; req_b0 = b;
      end else begin
         req_sel1 = sel; req_a1 = a; req_b1 = b;
      end
   endtask

   // Called just after a negedge; returns at a negedge+1 with some ready high.
   task automatic wait_ready(output bit ok);
      int n = 0;
      while (req_ready == 2'b00 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      ok = (req_ready != 2'b00);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got req_ready=%0b want nonzero", req_ready);
      end
   endtask

   // Single request with latency check; response consumed by the monitor.
   task automatic issue(input int id, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eo, input logic ec,
                        input logic ez);
      bit ok;
      exp_t e;
      @(negedge clk);
      drive(id, sel, a, b);
      req_valid[id] = 1'b1;
      #1;
      wait_ready(ok);
      chk("grant", 64'(req_ready), 64'(2'b01 << id));
      e.id = id[0]; e.out = eo; e.carry = ec; e.zero = ez;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      @(negedge clk);
      chk("exec_no_valid", 64'(rsp_valid), 64'd0);
      chk("exec_busy",     64'(busy),      64'd1);
      @(negedge clk);
      chk("latency_valid", 64'(rsp_valid), 64'd1);
   endtask

   logic        alt_id  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [2:0]  alt_sel [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
   logic [31:0] alt_a   [4] = '{32'd10, 32'd100, 32'd5, 32'h8000_0000};
   logic [31:0] alt_b   [4] = '{32'd20, 32'd1,   32'd7, 32'd1};
   logic [31:0] alt_o   [4] = '{32'd30, 32'd101, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
   logic        alt_c   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      #100000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      exp_t e;
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
      drive(0, 3'b0, 32'b0, 32'b0);
      drive(1, 3'b0, 32'b0, 32'b0);
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_out",   64'(rsp_out),   64'd0);
      rst_n = 1'b1;

      issue(0, 3'b000, 32'd3, 32'd88, 32'd91, 1'b0, 1'b0);
      issue(1, 3'b001, 32'd1, 32'd1,  32'd0,  1'b0, 1'b1);
      issue(0, 3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
      issue(0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);

      // Last grant was requester 0, so contention starts with requester 1.
      @(negedge clk);
      drive(1, alt_sel[0], alt_a[0], alt_b[0]);
      drive(0, alt_sel[1], alt_a[1], alt_b[1]);
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         wait_ready(ok);
         chk("alt_grant", 64'(req_ready), 64'(2'b01 << alt_id[k]));
         e.id = alt_id[k]; e.out = alt_o[k]; e.carry = alt_c[k]; e.zero = 1'b0;
         sb.push_back(e);
         @(posedge clk); #1;
         if (k == 0) drive(1, alt_sel[2], alt_a[2], alt_b[2]);
         if (k == 1) drive(0, alt_sel[3], alt_a[3], alt_b[3]);
         if (k == 2) req_valid[1] = 1'b0;
         if (k == 3) req_valid[0] = 1'b0;
         @(negedge clk); #1;
      end
      repeat (4) @(negedge clk);

      // Response stall with a competing request pending.
      rsp_ready = 1'b0;
      issue(0, 3'b000, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);
      req_valid[1] = 1'b1;
      drive(1, 3'b000, 32'd1, 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_valid",     64'(rsp_valid), 64'd1);
         chk("stall_out",       64'(rsp_out),   64'd11);
         chk("stall_id",        64'(rsp_id),    64'd0);
         chk("stall_req_ready", 64'(req_ready), 64'd0);
         chk("stall_busy",      64'(busy),      64'd1);
      end
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk("release_idle",  64'(busy),      64'd0);
      @(negedge clk);
      chk("single_xfer",   64'(rsp_valid), 64'd0);

      // Reset while EXEC: in-flight result dropped.
      drive(1, 3'b000, 32'd9, 32'd9);
      req_valid[1] = 1'b1;
      #1;
      wait_ready(ok);
      @(posedge clk); #1;
      req_valid = 2'b11;
      chk("pre_rst_exec", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy",      64'(busy),      64'd0);
      chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("arst_req_ready", 64'(req_ready), 64'd0);
      chk("arst_rsp_out",   64'(rsp_out),   64'd0);
      chk("arst_rsp_id",    64'(rsp_id),    64'd0);
      repeat (2) @(negedge clk);
      req_valid = 2'b00;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_no_valid", 64'(rsp_valid), 64'd0);
      end

      // Priority returned to requester 0 by reset.
      @(negedge clk);
      drive(0, 3'b000, 32'd2, 32'd2);
      drive(1, 3'b000, 32'd3, 32'd3);
      req_valid = 2'b11;
      #1;
      wait_ready(ok);
      chk("post_rst_prio", 64'(req_ready), 64'd1);
      e.id = 1'b0; e.out = 32'd4; e.carry = 1'b0; e.zero = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (6) @(negedge clk);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
